// File: rtl/i2c_txn_controller_pkg.sv
// i2c_txn_controller_pkg: shared encodings for the I2C transaction sequencer
// Holds the bus-engine command opcodes, control register bit positions and the FSM state enum.
package i2c_txn_controller_pkg;
    localparam int CTRL_RW       = 0;
    localparam int CTRL_ADDR_LSB = 1;
    localparam int CTRL_ADDR_MSB = 7;
    localparam int CTRL_BEGIN    = 9;
    localparam int CTRL_ABORT    = 11;

    typedef enum logic [1:0] {
        OP_START = 2'd0,
        OP_STOP  = 2'd1,
        OP_WRITE = 2'd2,
        OP_READ  = 2'd3
    } cmd_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_WRITE,
        S_READ,
        S_STOP,
        S_DONE
    } state_e;
endpackage

// File: rtl/i2c_txn_controller.sv
// i2c_txn_controller: turns one control-register request into START/ADDR/data/STOP bus commands
// Ports: clk/rst (async active-high); ctrl_reg/byte_count/clear_begin_trans to the control register;
// tx_fifo_* and rx_fifo_* to the data FIFOs; cmd_*/rsp_* to the bit-level bus engine;
// busy/done_irq/nack_err status.
module i2c_txn_controller
    import i2c_txn_controller_pkg::*;
#(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [11:0]      ctrl_reg,
    input  logic [CNT_W-1:0] byte_count,
    output logic             clear_begin_trans,
    input  logic             tx_fifo_empty,
    input  logic [7:0]       tx_fifo_data,
    output logic             tx_fifo_pop,
    input  logic             rx_fifo_full,
    output logic             rx_fifo_push,
    output logic [7:0]       rx_fifo_data,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [1:0]       cmd_op,
    output logic [7:0]       cmd_data,
    output logic             cmd_nack,
    input  logic             rsp_valid,
    input  logic [7:0]       rsp_data,
    input  logic             rsp_nack,
    output logic             busy,
    output logic             done_irq,
    output logic             nack_err
);
    localparam logic [CNT_W-1:0] ONE = 1;

    state_e           state_q, state_d;
    logic [6:0]       addr_q, addr_d;
    logic             rw_q, rw_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             abort_q, abort_d;
    logic             out_q, out_d;
    logic             nack_q, nack_d;
    logic             active, abort_now, accept, rsp, start_req;
    logic [CNT_W-1:0] rem_dec;
    cmd_op_e          op;
    logic             unused_ctrl;

    assign unused_ctrl = ^{ctrl_reg[10], ctrl_reg[8]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            rem_q   <= '0;
            abort_q <= 1'b0;
            out_q   <= 1'b0;
            nack_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            rem_q   <= rem_d;
            abort_q <= abort_d;
            out_q   <= out_d;
            nack_q  <= nack_d;
        end
    end

    always_comb begin
        active    = state_q inside {S_START, S_ADDR, S_WRITE, S_READ};
        abort_now = active && (abort_q || ctrl_reg[CTRL_ABORT]);
        rsp       = out_q && rsp_valid;
        rem_dec   = (rem_q == '0) ? rem_q : rem_q - ONE;
        start_req = state_q == S_IDLE && ctrl_reg[CTRL_BEGIN] && !ctrl_reg[CTRL_ABORT];
        op        = state_q == S_START ? OP_START :
                    state_q == S_STOP  ? OP_STOP  :
                    state_q == S_READ  ? OP_READ  : OP_WRITE;
        // a new command is presented only when nothing is outstanding and its data path is ready
        cmd_valid = !out_q && (state_q inside {S_START, S_ADDR, S_STOP} ||
                               (state_q == S_WRITE && !tx_fifo_empty) ||
                               (state_q == S_READ && !rx_fifo_full));
        cmd_op    = cmd_valid ? op : OP_START;
        cmd_data  = !cmd_valid         ? 8'h00 :
                    state_q == S_ADDR  ? {addr_q, rw_q} :
                    state_q == S_WRITE ? tx_fifo_data : 8'h00;
        cmd_nack  = cmd_valid && state_q == S_READ && rem_q == ONE;
        accept    = cmd_valid && cmd_ready;
        tx_fifo_pop  = accept && state_q == S_WRITE;
        rx_fifo_push = rsp && state_q == S_READ;
        rx_fifo_data = rx_fifo_push ? rsp_data : 8'h00;
        // gated by rst so every output reads 0 while reset is held, even with begin asserted
        clear_begin_trans = start_req && !rst;
        busy     = state_q != S_IDLE;
        done_irq = state_q == S_DONE;
        nack_err = nack_q;
        state_d = state_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        rem_d   = rem_q;
        nack_d  = nack_q;
        out_d   = accept ? 1'b1 : rsp ? 1'b0 : out_q;
        abort_d = state_q == S_DONE ? 1'b0 : abort_q || (active && ctrl_reg[CTRL_ABORT]);
        case (state_q)
            S_IDLE: if (start_req) begin
                state_d = S_START;
                addr_d  = ctrl_reg[CTRL_ADDR_MSB:CTRL_ADDR_LSB];
                rw_d    = ctrl_reg[CTRL_RW];
                rem_d   = byte_count;
                nack_d  = 1'b0;
            end
            S_START: if (rsp) state_d = abort_now ? S_STOP : S_ADDR;
            S_ADDR: if (rsp) begin
                nack_d  = nack_q || rsp_nack;
                state_d = (rsp_nack || abort_now || rem_q == '0) ? S_STOP : rw_q ? S_READ : S_WRITE;
            end
            S_WRITE: if (rsp) begin
                rem_d   = rem_dec;
                nack_d  = nack_q || rsp_nack;
                state_d = (rsp_nack || abort_now || rem_q <= ONE) ? S_STOP : S_WRITE;
            end
            S_READ: if (rsp) begin
                rem_d   = rem_dec;
                state_d = (abort_now || rem_q <= ONE) ? S_STOP : S_READ;
            end
            S_STOP: if (rsp) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // an abort with no command presented or in flight goes straight to STOP;
        // a presented command is still carried through its handshake and response first
        if (abort_now && !out_q && !cmd_valid) state_d = S_STOP;
    end
endmodule

// File: tb/tb_i2c_txn_controller.sv
// tb_i2c_txn_controller: directed bench with a bus-engine/FIFO model and a transaction-level expectation queue
module tb_i2c_txn_controller;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] ctrl_reg = '0;
    logic [5:0]  byte_count = '0;
    logic        clear_begin_trans, tx_fifo_pop, rx_fifo_push, cmd_valid, cmd_nack, busy, done_irq, nack_err;
    logic        tx_fifo_empty = 1'b1, rx_fifo_full = 1'b0, cmd_ready = 1'b1, rsp_valid = 1'b0, rsp_nack = 1'b0;
    logic [7:0]  tx_fifo_data = '0, rsp_data = '0, rx_fifo_data, cmd_data;
    logic [1:0]  cmd_op;

    always #5 clk = ~clk;

    i2c_txn_controller #(.CNT_W(6)) dut (
        .clk(clk), .rst(rst), .ctrl_reg(ctrl_reg), .byte_count(byte_count),
        .clear_begin_trans(clear_begin_trans), .tx_fifo_empty(tx_fifo_empty),
        .tx_fifo_data(tx_fifo_data), .tx_fifo_pop(tx_fifo_pop), .rx_fifo_full(rx_fifo_full),
        .rx_fifo_push(rx_fifo_push), .rx_fifo_data(rx_fifo_data), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_nack(cmd_nack),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_nack(rsp_nack), .busy(busy),
        .done_irq(done_irq), .nack_err(nack_err)
    );

    int checks = 0, passed = 0;
    logic [10:0] exp_cmd[$], log_cmd[$];
    logic [7:0]  exp_rx[$], log_rx[$], tx_q[$], rd_q[$];
    logic [11:0] ctrl_v = '0;
    int rdy_hold = 0, tx_block = 0, nack_at = -1, wr_idx = 0, lat = 0;
    int pops = 0, pushes = 0, dones = 0, clrs = 0, holds = 0, stalls = 0;
    bit outst = 0, fire = 0, addr_phase = 0, pv = 0, pa = 0, blk = 0;
    bit trig_block = 0, trig_rdy = 0, trig_abort = 0;
    logic [1:0] cur_op = '0, p_op = '0;
    logic [7:0] p_data = '0, fire_data = '0;
    logic       fire_nack = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [10:0] key(input logic [1:0] o, input logic [7:0] d, input logic n);
        return {o, o == 2'd2 ? d : 8'h00, o == 2'd3 ? n : 1'b0};
    endfunction

    // expected command stream of a transaction, derived from the request alone
    task automatic plan(input bit rw, input logic [6:0] a, input int n, input int nk);
        exp_cmd.delete();
        exp_rx.delete();
        exp_cmd.push_back(key(2'd0, 8'h00, 1'b0));
        exp_cmd.push_back(key(2'd2, {a, rw}, 1'b0));
        for (int i = 0; i < n && nk != 0; i++) begin
            if (rw) begin
                exp_cmd.push_back(key(2'd3, 8'h00, i == n - 1));
                exp_rx.push_back(rd_q[i]);
            end else exp_cmd.push_back(key(2'd2, tx_q[i], 1'b0));
            if (!rw && nk == i + 1) break;
        end
        exp_cmd.push_back(key(2'd1, 8'h00, 1'b0));
    endtask

    task automatic observe();
        bit acc;
        acc = cmd_valid && cmd_ready;
        if (pv && !pa) begin
            holds++;
            chk("hold_valid", cmd_valid, 1);
            chk("hold_op", cmd_op, p_op);
            chk("hold_data", cmd_data, p_data);
        end
        if (outst) chk("one_outstanding", cmd_valid, 0);
        if (blk) chk("stall_on_empty", cmd_valid, 0);
        if (blk && !outst) stalls++;
        chk("pop", tx_fifo_pop, acc && cmd_op == 2'd2 && !addr_phase);
        chk("push", rx_fifo_push, rsp_valid && outst && cur_op == 2'd3);
        if (acc) begin
            log_cmd.push_back({cmd_op, cmd_data, cmd_nack});
            if (exp_cmd.size() == 0) begin
                checks++;
                $display("FAIL cmd_extra: got op %0d data %0h with none expected", cmd_op, cmd_data);
            end else chk("cmd", key(cmd_op, cmd_data, cmd_nack), exp_cmd.pop_front());
            if (cmd_op == 2'd0) addr_phase = 1;
            else if (cmd_op == 2'd2) addr_phase = 0;
        end
        if (tx_fifo_pop) begin
            pops++;
            if (tx_q.size() > 0) void'(tx_q.pop_front());
            if (trig_block) begin trig_block = 0; tx_block = 8; end
        end
        if (rx_fifo_push) begin
            pushes++;
            log_rx.push_back(rx_fifo_data);
            if (exp_rx.size() == 0) begin
                checks++;
                $display("FAIL rx_extra: got %0h with none expected", rx_fifo_data);
            end else chk("rx_data", rx_fifo_data, exp_rx.pop_front());
        end
        if (done_irq) dones++;
        if (clear_begin_trans) clrs++;
        pv = cmd_valid; pa = acc; p_op = cmd_op; p_data = cmd_data;
        fire = 0;
        if (rsp_valid) outst = 0;
        if (acc) begin
            outst = 1; lat = 1; cur_op = cmd_op;
            fire_nack = cmd_op == 2'd2 && wr_idx == nack_at;
            if (cmd_op == 2'd2) wr_idx++;
            fire_data = (cmd_op == 2'd3 && rd_q.size() > 0) ? rd_q.pop_front() : 8'h00;
            if (trig_rdy && cmd_op == 2'd2) begin trig_rdy = 0; rdy_hold = 6; end
            if (trig_abort && cmd_op == 2'd3) begin trig_abort = 0; ctrl_v = 12'h800; end
        end else if (outst && !rsp_valid) begin
            if (lat == 0) fire = 1; else lat--;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        ctrl_reg = ctrl_v; ctrl_v = '0;
        rsp_valid = fire; rsp_data = fire ? fire_data : 8'h00; rsp_nack = fire && fire_nack;
        cmd_ready = rdy_hold == 0;
        if (rdy_hold > 0) rdy_hold--;
        blk = tx_block > 0;
        tx_fifo_empty = blk || tx_q.size() == 0;
        tx_fifo_data = tx_q.size() > 0 ? tx_q[0] : 8'h00;
        if (tx_block > 0) tx_block--;
        #1;
        observe();
    endtask

    task automatic txn(input bit rw, input logic [6:0] a, input int n, input int nk, input bit exp_nk,
                       input bit manual, input string tag);
        int c0, d0;
        c0 = clrs; d0 = dones;
        wr_idx = 0; nack_at = nk; addr_phase = 0;
        log_cmd.delete(); log_rx.delete();
        if (!manual) plan(rw, a, n, nk);
        byte_count = n[5:0];
        ctrl_v = {3'b001, 1'b0, a, rw};
        cyc();
        chk({tag, "_clear"}, clear_begin_trans, 1);
        chk({tag, "_busy_pre"}, busy, 0);
        cyc();
        chk({tag, "_busy"}, busy, 1);
        for (int i = 0; i < 400 && dones == d0; i++) cyc();
        chk({tag, "_done"}, dones - d0, 1);
        chk({tag, "_cmds_left"}, exp_cmd.size(), 0);
        chk({tag, "_rx_left"}, exp_rx.size(), 0);
        chk({tag, "_nack_err"}, nack_err, exp_nk);
        cyc();
        chk({tag, "_busy_post"}, busy, 0);
        chk({tag, "_done_once"}, dones - d0, 1);
        chk({tag, "_clear_once"}, clrs - c0, 1);
    endtask

    initial begin
        logic [10:0] e;
        int p0, u0;
        #2;
        chk("reset_outputs", {clear_begin_trans, tx_fifo_pop, rx_fifo_push, rx_fifo_data, cmd_valid,
                              cmd_op, cmd_data, cmd_nack, busy, done_irq, nack_err}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cyc();

        tx_q = '{8'hA5, 8'h3C}; p0 = pops;
        txn(0, 7'h50, 2, -1, 0, 0, "wr");
        chk("wr_ncmd", log_cmd.size(), 5);
        e = log_cmd[1]; chk("wr_addr_lit", e[8:1], 8'hA0);
        e = log_cmd[2]; chk("wr_d0_lit", e[8:1], 8'hA5);
        e = log_cmd[3]; chk("wr_d1_lit", e[8:1], 8'h3C);
        e = log_cmd[4]; chk("wr_stop_lit", e[10:9], 2'd1);
        chk("wr_pops", pops - p0, 2);

        rd_q = '{8'h11, 8'h22, 8'h33};
        txn(1, 7'h50, 3, -1, 0, 0, "rd");
        e = log_cmd[1]; chk("rd_addr_lit", e[8:1], 8'hA1);
        e = log_cmd[2]; chk("rd_nack0_lit", {e[10:9], e[0]}, 3'b110);
        e = log_cmd[3]; chk("rd_nack1_lit", {e[10:9], e[0]}, 3'b110);
        e = log_cmd[4]; chk("rd_nack2_lit", {e[10:9], e[0]}, 3'b111);
        chk("rd_rx_lit", {log_rx[0], log_rx[1], log_rx[2]}, 24'h112233);

        tx_q = '{8'h77, 8'h88}; p0 = pops; u0 = pushes;
        txn(0, 7'h50, 2, 0, 1, 0, "anack");
        chk("anack_ncmd", log_cmd.size(), 3);
        chk("anack_fifo", (pops - p0) + (pushes - u0), 0);
        tx_q.delete();

        txn(0, 7'h10, 0, -1, 0, 0, "probe");
        e = log_cmd[1]; chk("probe_addr_lit", e[8:1], 8'h20);

        tx_q = '{8'h01, 8'h02, 8'h03};
        trig_rdy = 1; trig_block = 1; holds = 0; stalls = 0;
        txn(0, 7'h2A, 3, -1, 0, 0, "bp");
        chk("bp_held3", holds >= 3, 1);
        chk("bp_stall5", stalls >= 5, 1);

        rd_q = '{8'h11, 8'h22, 8'h33}; u0 = pushes;
        exp_cmd = '{key(2'd0, 8'h00, 1'b0), key(2'd2, 8'hA1, 1'b0), key(2'd3, 8'h00, 1'b0), key(2'd1, 8'h00, 1'b0)};
        exp_rx = '{8'h11};
        trig_abort = 1;
        txn(1, 7'h50, 3, -1, 0, 1, "abort");
        chk("abort_pushes", pushes - u0, 1);
        rd_q.delete();

        p0 = clrs;
        ctrl_v = 12'hA00 | 12'h0A1;
        cyc();
        chk("begin_abort_clear", clear_begin_trans, 0);
        repeat (8) cyc();
        chk("begin_abort_busy", busy, 0);
        chk("begin_abort_cmds", log_cmd.size(), 4);
        chk("begin_abort_clrs", clrs - p0, 0);

        fire = 1; fire_data = 8'h5A;
        repeat (3) cyc();
        chk("spurious_rsp_busy", busy, 0);

        tx_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4}; p0 = pops;
        wr_idx = 0; nack_at = -1; addr_phase = 0;
        plan(0, 7'h33, 4, -1);
        byte_count = 6'd4; ctrl_v = {3'b001, 1'b0, 7'h33, 1'b0};
        for (int i = 0; i < 200 && pops == p0; i++) cyc();
        chk("rst_reached_write", pops - p0, 1);
        chk("rst_busy_before", busy, 1);
        #1 rst = 1'b1;
        #1 chk("rst_outputs", {clear_begin_trans, tx_fifo_pop, rx_fifo_push, rx_fifo_data, cmd_valid,
                               cmd_op, cmd_data, cmd_nack, busy, done_irq, nack_err}, 0);
        outst = 0; fire = 0; pv = 0; pa = 0; rdy_hold = 0; tx_block = 0;
        exp_cmd.delete(); tx_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tx_q = '{8'hA5, 8'h3C};
        txn(0, 7'h50, 2, -1, 0, 0, "post_rst");
        chk("post_rst_ncmd", log_cmd.size(), 5);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
